mem_ctrl: RTL and testbench

CPU-side initiator of the byte-serial memory bus (mem_a / mem_wr / mem_dout / mem_din) that the top level routes to the 128 KiB RAM and the HCI I/O window. It arbitrates between the instruction-fetch path and the load/store path and splits each 1/2/4-byte request into consecutive byte cycles. It assembles read data little-endian. It honours the bus pause signal (rdy_in) and the HCI output-buffer back-pressure (io_buffer_full).

---
 rtl/mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-side initiator of the byte-serial memory bus.
// Arbitrates between instruction fetch (IF) and load/store (LS). LS always wins.
// Splits each 1/2/4-byte request into consecutive byte cycles at ascending addresses.
// Read data is assembled little-endian.
// Honours bus pause (rdy_in) and HCI output back-pressure (io_buffer_full).
//
// Ports:
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   rdy_in                    bus granted this cycle (low = paused)
//   mem_din/mem_dout/mem_a/mem_wr   byte bus (read data arrives one cycle after address)
//   io_buffer_full            HCI output FIFO full (applies to I/O writes only)
//   flush                     cancel an instruction fetch
//   if_valid/if_addr/if_done/if_data                 word fetch port
//   ls_valid/ls_we/ls_size/ls_addr/ls_wdata/ls_done/ls_rdata   load/store port
//
// state | meaning
// IDLE  | no transaction; accepts LS first, otherwise IF (unless flush)
// READ  | pipelined byte reads; iss_q = next byte to address, cap_q = next byte to capture
// WRITE | one byte per cycle; iss_q = byte currently on the bus
module mem_ctrl #(
   parameter int RAM_ADDR_WIDTH = 17
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        flush,
   input  logic        if_valid,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_valid,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t      state_q, state_d;
   logic        is_ls_q, is_ls_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  n_q, n_d;
   logic [2:0]  iss_q, iss_d;
   logic [2:0]  cap_q, cap_d;
   logic        addr_v_q, addr_v_d;   // mem_a this cycle is a live read address
   logic        data_v_q, data_v_d;   // mem_din this cycle holds byte cap_q
   logic        gap_q, gap_d;         // idle cycle after an I/O byte write
   logic [31:0] buf_q, buf_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic        mem_wr_q, mem_wr_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        if_done_q, if_done_d;
   logic        ls_done_q, ls_done_d;
   logic [31:0] if_data_q, if_data_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;

   logic        io_cur;
   logic        wr_fire;
   logic [2:0]  cap_nx;
   logic [2:0]  iss_nx;
   logic [31:0] rd_word;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   assign io_cur  = (mem_a_q[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11);
   // A write only happens when the bus is ours and, for I/O, the FIFO has room.
   assign wr_fire = mem_wr_q && rdy_in && !(io_cur && io_buffer_full);
   assign cap_nx  = cap_q + 3'd1;
   assign iss_nx  = iss_q + 3'd1;

   assign mem_wr   = wr_fire;
   assign mem_dout = wr_fire ? mem_dout_q : 8'h00;
   assign mem_a    = mem_a_q;
   assign if_done  = if_done_q;
   assign ls_done  = ls_done_q;
   assign if_data  = if_data_q;
   assign ls_rdata = ls_rdata_q;

   always_comb begin
      rd_word = buf_q;
      case (cap_q[1:0])
         2'd0:    rd_word[7:0]   = mem_din;
         2'd1:    rd_word[15:8]  = mem_din;
         2'd2:    rd_word[23:16] = mem_din;
         default: rd_word[31:24] = mem_din;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      is_ls_d    = is_ls_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      n_d        = n_q;
      iss_d      = iss_q;
      cap_d      = cap_q;
      addr_v_d   = addr_v_q;
      data_v_d   = data_v_q;
      gap_d      = gap_q;
      buf_d      = buf_q;
      mem_a_d    = mem_a_q;
      mem_wr_d   = mem_wr_q;
      mem_dout_d = mem_dout_q;
      if_data_d  = if_data_q;
      ls_rdata_d = ls_rdata_q;
      if_done_d  = 1'b0;
      ls_done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (ls_valid) begin
               is_ls_d = 1'b1;
               base_d  = ls_addr;
               wdata_d = ls_wdata;
               case (ls_size)
                  2'b00:   n_d = 3'd1;
                  2'b01:   n_d = 3'd2;
                  default: n_d = 3'd4;
               endcase
               mem_a_d = ls_addr;
               buf_d   = 32'h0;
               cap_d   = 3'd0;
               gap_d   = 1'b0;
               if (ls_we) begin
                  state_d    = WRITE;
                  iss_d      = 3'd0;
                  mem_wr_d   = 1'b1;
                  mem_dout_d = ls_wdata[7:0];
               end else begin
                  state_d  = READ;
                  iss_d    = 3'd1;
                  addr_v_d = 1'b1;
                  data_v_d = 1'b0;
               end
            end else if (if_valid && !flush) begin
               state_d  = READ;
               is_ls_d  = 1'b0;
               base_d   = if_addr;
               n_d      = 3'd4;
               mem_a_d  = if_addr;
               buf_d    = 32'h0;
               cap_d    = 3'd0;
               iss_d    = 3'd1;
               addr_v_d = 1'b1;
               data_v_d = 1'b0;
            end
         end

         READ: begin
            if (flush && !is_ls_q) begin
               state_d  = IDLE;
               addr_v_d = 1'b0;
               data_v_d = 1'b0;
            end else if (!rdy_in) begin
               // Drop whatever was in flight and keep re-presenting the oldest
               // uncaptured byte so it is serviced as soon as the bus returns.
               data_v_d = 1'b0;
               addr_v_d = 1'b1;
               iss_d    = cap_nx;
               mem_a_d  = base_q + {29'd0, cap_q};
            end else if (data_v_q && (cap_nx == n_q)) begin
               state_d  = IDLE;
               addr_v_d = 1'b0;
               data_v_d = 1'b0;
               if (is_ls_q) begin
                  ls_done_d  = 1'b1;
                  ls_rdata_d = rd_word;
               end else begin
                  if_done_d = 1'b1;
                  if_data_d = rd_word;
               end
            end else begin
               if (data_v_q) begin
                  buf_d = rd_word;
                  cap_d = cap_nx;
               end
               data_v_d = addr_v_q;
               if (iss_q < n_q) begin
                  mem_a_d  = base_q + {29'd0, iss_q};
                  iss_d    = iss_nx;
                  addr_v_d = 1'b1;
               end else begin
                  addr_v_d = 1'b0;
               end
            end
         end

         WRITE: begin
            if (wr_fire) begin
               if (iss_nx == n_q) begin
                  state_d   = IDLE;
                  mem_wr_d  = 1'b0;
                  ls_done_d = 1'b1;
               end else begin
                  iss_d = iss_nx;
                  if (io_cur) begin
                     // io_buffer_full lags a cycle, so give it one before the next byte.
                     mem_wr_d = 1'b0;
                     gap_d    = 1'b1;
                  end else begin
                     mem_a_d    = base_q + {29'd0, iss_nx};
                     mem_dout_d = byte_sel(wdata_q, iss_nx[1:0]);
                  end
               end
            end else if (gap_q && rdy_in) begin
               gap_d      = 1'b0;
               mem_wr_d   = 1'b1;
               mem_a_d    = base_q + {29'd0, iss_q};
               mem_dout_d = byte_sel(wdata_q, iss_q[1:0]);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         is_ls_q    <= 1'b0;
         base_q     <= 32'h0;
         wdata_q    <= 32'h0;
         n_q        <= 3'd0;
         iss_q      <= 3'd0;
         cap_q      <= 3'd0;
         addr_v_q   <= 1'b0;
         data_v_q   <= 1'b0;
         gap_q      <= 1'b0;
         buf_q      <= 32'h0;
         mem_a_q    <= 32'h0;
         mem_wr_q   <= 1'b0;
         mem_dout_q <= 8'h0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
         if_data_q  <= 32'h0;
         ls_rdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         is_ls_q    <= is_ls_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         n_q        <= n_d;
         iss_q      <= iss_d;
         cap_q      <= cap_d;
         addr_v_q   <= addr_v_d;
         data_v_q   <= data_v_d;
         gap_q      <= gap_d;
         buf_q      <= buf_d;
         mem_a_q    <= mem_a_d;
         mem_wr_q   <= mem_wr_d;
         mem_dout_q <= mem_dout_d;
         if_done_q  <= if_done_d;
         ls_done_q  <= ls_done_d;
         if_data_q  <= if_data_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-serial RAM model plus hand-computed expectations.
module tb_mem_ctrl;

   logic        clk_in;
   logic        rst_n_in;
   logic        rdy_in;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        ls_valid;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;

   mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .flush(flush),
      .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // RAM model: read byte appears one cycle after its address; unserviced cycles return junk.
   logic [7:0] ram [0:262143];
   int n_wr;
   always @(posedge clk_in) begin
      mem_din <= rdy_in ? ram[mem_a[17:0]] : 8'hEE;
      if (mem_wr) begin
         ram[mem_a[17:0]] = mem_dout;
         n_wr = n_wr + 1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic poke32(input logic [31:0] a, input logic [31:0] w);
      ram[a[17:0]]        = w[7:0];
      ram[a[17:0] + 18'd1] = w[15:8];
      ram[a[17:0] + 18'd2] = w[23:16];
      ram[a[17:0] + 18'd3] = w[31:24];
   endtask

   function automatic logic [31:0] peek32(input logic [31:0] a);
      return {ram[a[17:0] + 18'd3], ram[a[17:0] + 18'd2], ram[a[17:0] + 18'd1], ram[a[17:0]]};
   endfunction

   task automatic ls_req(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      ls_valid = 1'b1;
      ls_we    = we;
      ls_size  = sz;
      ls_addr  = a;
      ls_wdata = d;
   endtask

   int wr0;
   logic [31:0] exp_a3 [10] = '{32'h300, 32'h301, 32'h302, 32'h301, 32'h301,
                                32'h301, 32'h302, 32'h303, 32'h303, 32'h303};
   logic [7:0]  st_bytes;
   logic [31:0] st_word;

   initial begin
      n_wr = 0;
      for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
      rst_n_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
      if_valid = 1'b0; if_addr = 32'h0;
      ls_valid = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;
      poke32(32'h100, 32'h0010_0513);
      poke32(32'h104, 32'h1234_5678);
      poke32(32'h300, 32'hD4C3_B2A1);

      tick(); tick();
      chk("rst mem_a", mem_a, 32'h0);
      chk("rst mem_wr", mem_wr, 0);
      chk("rst mem_dout", mem_dout, 0);
      chk("rst if_done", if_done, 0);
      chk("rst ls_done", ls_done, 0);
      chk("rst if_data", if_data, 0);
      chk("rst ls_rdata", ls_rdata, 0);
      rst_n_in = 1'b1;
      tick();

      // Word fetch: addresses on consecutive cycles, done in cycle 5 after accept.
      if_valid = 1'b1; if_addr = 32'h100;
      for (int c = 0; c <= 5; c++) begin
         tick();
         chk($sformatf("fetch mem_a c%0d", c), mem_a, 32'h100 + ((c < 3) ? c : 3));
         chk($sformatf("fetch if_done c%0d", c), if_done, (c == 5));
         chk($sformatf("fetch mem_wr c%0d", c), mem_wr, 0);
      end
      chk("fetch if_data", if_data, 32'h0010_0513);
      if_valid = 1'b0;
      tick();
      chk("fetch done one cycle", if_done, 0);
      chk("fetch if_data held", if_data, 32'h0010_0513);

      // Store-first arbitration: sh 0xBEEF to 0x200 with fetch of 0x104 pending.
      ls_req(1'b1, 2'b01, 32'h200, 32'hDEAD_BEEF);
      if_valid = 1'b1; if_addr = 32'h104;
      tick();
      chk("sh c0 wr", mem_wr, 1); chk("sh c0 a", mem_a, 32'h200); chk("sh c0 d", mem_dout, 32'hEF);
      tick();
      chk("sh c1 wr", mem_wr, 1); chk("sh c1 a", mem_a, 32'h201); chk("sh c1 d", mem_dout, 32'hBE);
      tick();
      chk("sh c2 wr", mem_wr, 0); chk("sh c2 ls_done", ls_done, 1); chk("sh c2 d", mem_dout, 0);
      ls_valid = 1'b0;
      tick();
      chk("sh then fetch a", mem_a, 32'h104); chk("sh ls_done pulse", ls_done, 0);
      for (int c = 4; c <= 8; c++) begin
         tick();
         chk($sformatf("fetch2 if_done c%0d", c), if_done, (c == 8));
      end
      chk("fetch2 if_data", if_data, 32'h1234_5678);
      if_valid = 1'b0;
      chk("sh ram", peek32(32'h200), 32'h0000_BEEF);

      // Word load with rdy_in low during cycles 2..4 (edges E3..E5).
      tick();
      wr0 = n_wr;
      ls_req(1'b0, 2'b10, 32'h300, 32'h0);
      for (int c = 0; c <= 9; c++) begin
         tick();
         chk($sformatf("lw stall mem_a c%0d", c), mem_a, exp_a3[c]);
         chk($sformatf("lw stall mem_wr c%0d", c), mem_wr, 0);
         chk($sformatf("lw stall ls_done c%0d", c), ls_done, (c == 9));
         rdy_in = !(c >= 2 && c <= 4);
      end
      chk("lw stall rdata", ls_rdata, 32'hD4C3_B2A1);
      chk("lw stall no writes", n_wr - wr0, 0);
      ls_valid = 1'b0;

      // Byte load, zero-extended, done two edges after accept.
      tick();
      ls_req(1'b0, 2'b00, 32'h301, 32'h0);
      tick(); chk("lb c0 a", mem_a, 32'h301);
      tick(); chk("lb c1 done", ls_done, 0);
      tick(); chk("lb c2 done", ls_done, 1); chk("lb rdata", ls_rdata, 32'h0000_00B2);
      ls_valid = 1'b0;

      // Word store to RAM: done four edges after accept.
      tick();
      st_word = 32'h1122_3344;
      ls_req(1'b1, 2'b10, 32'h500, st_word);
      for (int c = 0; c <= 4; c++) begin
         tick();
         st_bytes = st_word[7:0];
         chk($sformatf("sw c%0d wr", c), mem_wr, (c < 4));
         chk($sformatf("sw c%0d done", c), ls_done, (c == 4));
         if (c < 4) begin
            chk($sformatf("sw c%0d a", c), mem_a, 32'h500 + c);
            chk($sformatf("sw c%0d d", c), mem_dout, st_bytes);
            st_word = st_word >> 8;
         end
      end
      ls_valid = 1'b0;
      chk("sw ram", peek32(32'h500), 32'h1122_3344);

      // I/O byte store held off by io_buffer_full.
      tick();
      wr0 = n_wr;
      io_buffer_full = 1'b1;
      ls_req(1'b1, 2'b00, 32'h3_0000, 32'h0000_0041);
      for (int c = 0; c <= 4; c++) begin
         tick();
         chk($sformatf("io full wr c%0d", c), mem_wr, 0);
         chk($sformatf("io full done c%0d", c), ls_done, 0);
      end
      io_buffer_full = 1'b0;
      #1;
      chk("io wr", mem_wr, 1); chk("io a", mem_a, 32'h3_0000); chk("io d", mem_dout, 32'h41);
      tick();
      chk("io after wr", mem_wr, 0); chk("io done", ls_done, 1);
      ls_valid = 1'b0;
      chk("io single write", n_wr - wr0, 1);
      chk("io ram", ram[18'h3_0000], 32'h41);

      // Two-byte I/O store then a back-to-back I/O byte store: idle cycle after each I/O byte.
      tick();
      ls_req(1'b1, 2'b01, 32'h3_0000, 32'h0000_5A59);
      for (int c = 0; c <= 5; c++) begin
         tick();
         chk($sformatf("io2 wr c%0d", c), mem_wr, (c % 2 == 0));
         chk($sformatf("io2 done c%0d", c), ls_done, (c == 3 || c == 5));
         if (c == 0) chk("io2 d0", mem_dout, 32'h59);
         if (c == 1) chk("io2 a1 held", mem_a, 32'h3_0000);
         if (c == 2) begin chk("io2 a2", mem_a, 32'h3_0001); chk("io2 d2", mem_dout, 32'h5A); end
         if (c == 4) chk("io2 d4", mem_dout, 32'h33);
         if (c == 3) ls_req(1'b1, 2'b00, 32'h3_0000, 32'h0000_0033);
      end
      ls_valid = 1'b0;

      // Flush on the second byte of a fetch.
      tick();
      if_valid = 1'b1; if_addr = 32'h100;
      tick(); chk("fl c0 a", mem_a, 32'h100);
      tick(); chk("fl c1 a", mem_a, 32'h101);
      flush = 1'b1;
      tick(); chk("fl c2 done", if_done, 0); chk("fl c2 a", mem_a, 32'h101);
      tick(); chk("fl c3 not accepted", mem_a, 32'h101);
      if_valid = 1'b0; flush = 1'b0;
      for (int c = 4; c <= 7; c++) begin
         tick();
         chk($sformatf("fl c%0d done", c), if_done, 0);
      end
      chk("fl if_data held", if_data, 32'h1234_5678);
      if_valid = 1'b1; if_addr = 32'h100;
      for (int c = 0; c <= 5; c++) begin
         tick();
         chk($sformatf("fl refetch done c%0d", c), if_done, (c == 5));
      end
      chk("fl refetch data", if_data, 32'h0010_0513);
      if_valid = 1'b0;

      // Reset during the third byte of a word store.
      tick();
      ls_req(1'b1, 2'b10, 32'h400, 32'hCAFE_F00D);
      tick(); chk("rs c0 wr", mem_wr, 1);
      tick(); chk("rs c1 wr", mem_wr, 1);
      tick(); chk("rs c2 wr", mem_wr, 1); chk("rs c2 a", mem_a, 32'h402);
      rst_n_in = 1'b0; ls_valid = 1'b0;
      tick();
      chk("rs mem_wr", mem_wr, 0); chk("rs mem_a", mem_a, 0); chk("rs mem_dout", mem_dout, 0);
      chk("rs ls_done", ls_done, 0); chk("rs if_done", if_done, 0);
      chk("rs if_data", if_data, 0); chk("rs ls_rdata", ls_rdata, 0);
      rst_n_in = 1'b1;
      for (int c = 4; c <= 7; c++) begin
         tick();
         chk($sformatf("rs after wr c%0d", c), mem_wr, 0);
         chk($sformatf("rs after done c%0d", c), ls_done, 0);
      end
      chk("rs byte3 unwritten", ram[18'h403], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
